// File: rtl/transport_receive.sv
// Receive-side transport stage: parses framed packets from the send stage, verifies the
// XOR checksum and commits payload words into a FIFO only for verified packets.
module transport_receive #(
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sending,
    input  logic [7:0]            packetIn,
    input  logic                  readData,
    output logic [1:0]            cmd,
    output logic                  cmdValid,
    output logic                  pktError,
    output logic [15:0]           data,
    output logic                  dataAvail,
    output logic [DEPTH_LOG2:0]   ready_data_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [15:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_rptr;
    logic [PW-1:0]   r_wptr_c;
    logic [PW-1:0]   r_wptr_s;
    logic [3:0]      r_rem;
    logic [7:0]      r_csum;
    logic [7:0]      r_hi;
    logic            r_ovf;
    logic [1:0]      r_cmd_pend;
    logic [1:0]      r_cmd;
    logic            r_cmd_valid;
    logic            r_pkt_error;

    logic [PW-1:0]   w_count;
    logic [PW-1:0]   w_used_s;
    logic            w_avail;
    logic            w_space;
    logic            w_wr;
    logic [7:0]      w_csum_nxt;

    // Space is judged against committed plus speculative words, using the current read pointer.
    assign w_count    = r_wptr_c - r_rptr;
    assign w_used_s   = r_wptr_s - r_rptr;
    assign w_avail    = (w_count != '0);
    assign w_space    = (w_used_s < PW'(DEPTH));
    assign w_csum_nxt = r_csum ^ packetIn;
    assign w_wr       = reset && sending && (r_state == S_LO) && w_space;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr_s[DEPTH_LOG2-1:0]] <= {r_hi, packetIn};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rptr      <= '0;
            r_wptr_c    <= '0;
            r_wptr_s    <= '0;
            r_rem       <= '0;
            r_csum      <= '0;
            r_hi        <= '0;
            r_ovf       <= 1'b0;
            r_cmd_pend  <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_pkt_error <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_pkt_error <= 1'b0;

            if (readData && w_avail) begin
                r_rptr <= r_rptr + PW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (sending) begin
                        r_cmd_pend <= packetIn[7:6];
                        r_rem      <= packetIn[3:0];
                        r_csum     <= packetIn;
                        r_ovf      <= 1'b0;
                        r_wptr_s   <= r_wptr_c;
                        r_state    <= (packetIn[3:0] == 4'd0) ? S_CHK : S_HI;
                    end
                end
                S_HI: begin
                    if (!sending) begin
                        r_pkt_error <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_hi    <= packetIn;
                        r_csum  <= w_csum_nxt;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (!sending) begin
                        r_pkt_error <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_csum <= w_csum_nxt;
                        if (w_space) begin
                            r_wptr_s <= r_wptr_s + PW'(1);
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        r_rem   <= r_rem - 4'd1;
                        r_state <= (r_rem == 4'd1) ? S_CHK : S_HI;
                    end
                end
                S_CHK: begin
                    if (!sending) begin
                        r_pkt_error <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        if ((packetIn == r_csum) && !r_ovf) begin
                            r_wptr_c    <= r_wptr_s;
                            r_cmd       <= r_cmd_pend;
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_pkt_error <= 1'b1;
                        end
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!sending) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd              = r_cmd;
    assign cmdValid         = r_cmd_valid;
    assign pktError         = r_pkt_error;
    assign ready_data_count = w_count;
    assign dataAvail        = w_avail;
    assign data             = w_avail ? r_mem[r_rptr[DEPTH_LOG2-1:0]] : 16'h0000;

endmodule

// File: tb/tb_transport_receive.sv
// Bench for transport_receive: byte-counting packet model with committed/speculative word
// queues, compared every cycle, plus directed scenarios with literal expectations.
module tb_transport_receive;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sending = 1'b0;
    logic [7:0]  packetIn = 8'h00;
    logic        readData = 1'b0;
    logic [1:0]  cmd;
    logic        cmdValid;
    logic        pktError;
    logic [15:0] data;
    logic        dataAvail;
    logic [5:0]  ready_data_count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    transport_receive #(.DEPTH_LOG2(5)) dut (
        .clk(clk), .reset(rst_n), .sending(sending), .packetIn(packetIn),
        .readData(readData), .cmd(cmd), .cmdValid(cmdValid), .pktError(pktError),
        .data(data), .dataAvail(dataAvail), .ready_data_count(ready_data_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: packet parsed by byte position, words held in queues
    logic [15:0] mq[$];
    logic [15:0] spec[$];
    logic [15:0] tmp_w;
    logic [1:0]  m_cmd = 2'd0;
    logic        m_cv = 1'b0;
    logic        m_pe = 1'b0;
    bit          in_pkt = 1'b0;
    bit          drain = 1'b0;
    bit          m_pop, m_commit, p_ovf;
    int          k, p_n, old_sz;
    logic [1:0]  p_cmd;
    logic [7:0]  p_cs, p_hi;

    always @(posedge clk) begin
        old_sz = mq.size();
        m_cv = 1'b0;
        m_pe = 1'b0;
        if (!rst_n) begin
            mq.delete();
            spec.delete();
            m_cmd = 2'd0;
            in_pkt = 1'b0;
            drain = 1'b0;
        end else begin
            m_pop = readData && (old_sz > 0);
            m_commit = 1'b0;
            if (!sending) begin
                if (in_pkt) m_pe = 1'b1;
                in_pkt = 1'b0;
                drain = 1'b0;
            end else if (drain) begin
                drain = 1'b1;
            end else if (!in_pkt) begin
                p_n = int'(packetIn[3:0]);
                p_cmd = packetIn[7:6];
                p_cs = packetIn;
                p_ovf = 1'b0;
                spec.delete();
                k = 1;
                in_pkt = 1'b1;
            end else if (k <= 2 * p_n) begin
                p_cs = p_cs ^ packetIn;
                if (k % 2 == 1) p_hi = packetIn;
                else if (old_sz + spec.size() < DEPTH) spec.push_back({p_hi, packetIn});
                else p_ovf = 1'b1;
                k++;
            end else begin
                if (packetIn == p_cs && !p_ovf) begin
                    m_commit = 1'b1;
                    m_cmd = p_cmd;
                    m_cv = 1'b1;
                end else begin
                    m_pe = 1'b1;
                end
                in_pkt = 1'b0;
                drain = 1'b1;
            end
            if (m_pop) tmp_w = mq.pop_front();
            if (m_commit) foreach (spec[i]) mq.push_back(spec[i]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cmd", 16'(cmd), 16'(m_cmd));
            cmp("cmdValid", 16'(cmdValid), 16'(m_cv));
            cmp("pktError", 16'(pktError), 16'(m_pe));
            cmp("count", 16'(ready_data_count), 16'(mq.size()));
            cmp("dataAvail", 16'(dataAvail), 16'(mq.size() != 0));
            cmp("data", data, (mq.size() != 0) ? mq[0] : 16'h0000);
        end
    end

    task automatic step(input logic s, input logic [7:0] b, input logic rd);
        @(negedge clk);
        sending = s;
        packetIn = b;
        readData = rd;
    endtask

    logic [7:0] pb[$];

    // Builds header, payload and checksum; bad flips the checksum's two low bits
    task automatic build(input logic [1:0] c, input int n, input logic [15:0] w0,
                         input bit rnd, input bit bad);
        logic [7:0] cs;
        logic [15:0] w;
        pb.delete();
        pb.push_back({c, rnd ? 2'($urandom_range(0, 3)) : 2'b00, 4'(n)});
        cs = pb[0];
        for (int i = 0; i < n; i++) begin
            w = rnd ? 16'($urandom) : w0 + 16'(i);
            pb.push_back(w[15:8]);
            pb.push_back(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        pb.push_back(bad ? (cs ^ 8'h03) : cs);
    endtask

    task automatic send(input int len, input int pop_a, input int pop_b, input int pct);
        for (int i = 0; i < len; i++)
            step(1'b1, pb[i], (i == pop_a) || (i == pop_b) || ($urandom_range(0, 99) < pct));
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        cmp("rst_count", 16'(ready_data_count), 16'h0);
        cmp("rst_data", data, 16'h0);

        // Basic packet then pop
        build(2'd1, 1, 16'h0044, 1'b0, 1'b0);
        cmp("pkt1_csum", 16'(pb[3]), 16'h0005);
        send(4, -1, -1, 0);
        step(1'b0, 8'h00, 1'b0);
        cmp("pkt1_cv", 16'(cmdValid), 16'h1);
        cmp("pkt1_cmd", 16'(cmd), 16'h1);
        cmp("pkt1_count", 16'(ready_data_count), 16'h1);
        cmp("pkt1_data", data, 16'h0044);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        cmp("pop_count", 16'(ready_data_count), 16'h0);
        cmp("pop_avail", 16'(dataAvail), 16'h0);
        cmp("pop_data", data, 16'h0);

        // Bad checksum
        build(2'd1, 1, 16'h0044, 1'b0, 1'b1);
        cmp("bad_csum", 16'(pb[3]), 16'h0006);
        send(4, -1, -1, 0);
        step(1'b0, 8'h00, 1'b0);
        cmp("bad_pe", 16'(pktError), 16'h1);
        cmp("bad_cv", 16'(cmdValid), 16'h0);
        cmp("bad_count", 16'(ready_data_count), 16'h0);

        // Truncation then a valid packet
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        cmp("trunc_pe", 16'(pktError), 16'h1);
        cmp("trunc_count", 16'(ready_data_count), 16'h0);
        build(2'd3, 2, 16'h1234, 1'b0, 1'b0);
        send(6, -1, -1, 0);
        step(1'b0, 8'h00, 1'b0);
        cmp("after_cv", 16'(cmdValid), 16'h1);
        cmp("after_count", 16'(ready_data_count), 16'h2);
        cmp("after_data", data, 16'h1234);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // Command-only packet
        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'h80, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        cmp("cmdonly_cv", 16'(cmdValid), 16'h1);
        cmp("cmdonly_cmd", 16'(cmd), 16'h2);
        cmp("cmdonly_count", 16'(ready_data_count), 16'h0);

        // Fill to 30, overflow, then pop-assisted commit
        build(2'd0, 15, 16'h1000, 1'b0, 1'b0);
        send(32, -1, -1, 0);
        step(1'b0, 8'h00, 1'b0);
        build(2'd0, 15, 16'h2000, 1'b0, 1'b0);
        send(32, -1, -1, 0);
        step(1'b0, 8'h00, 1'b0);
        cmp("fill_count", 16'(ready_data_count), 16'd30);
        build(2'd3, 3, 16'h3000, 1'b0, 1'b0);
        send(8, -1, -1, 0);
        step(1'b0, 8'h00, 1'b0);
        cmp("ovf_pe", 16'(pktError), 16'h1);
        cmp("ovf_count", 16'(ready_data_count), 16'd30);
        cmp("ovf_data", data, 16'h1000);
        send(8, 1, 7, 0);
        step(1'b0, 8'h00, 1'b0);
        cmp("popc_cv", 16'(cmdValid), 16'h1);
        cmp("popc_count", 16'(ready_data_count), 16'd31);
        cmp("popc_data", data, 16'h1002);

        // Reset in the middle of a packet
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        packetIn = 8'h55;
        @(negedge clk);
        rst_n = 1'b1;
        sending = 1'b0;
        cmp("mrst_count", 16'(ready_data_count), 16'h0);
        cmp("mrst_pe", 16'(pktError), 16'h0);
        cmp("mrst_cmd", 16'(cmd), 16'h0);
        cmp("mrst_data", data, 16'h0);
        step(1'b0, 8'h00, 1'b0);
        cmp("mrst_pe2", 16'(pktError), 16'h0);

        // Randomized traffic
        for (int p = 0; p < 240; p++) begin
            int n, len, pct;
            n = $urandom_range(0, 15);
            pct = ((p / 40) % 2 == 0) ? 10 : 60;
            build(2'($urandom_range(0, 3)), n, 16'h0, 1'b1, ($urandom_range(0, 7) == 0));
            len = pb.size();
            if ($urandom_range(0, 9) == 0) len = $urandom_range(1, pb.size() - 1);
            else if ($urandom_range(0, 5) == 0)
                for (int e = 0; e < $urandom_range(1, 3); e++) begin
                    pb.push_back(8'($urandom));
                    len++;
                end
            send(len, -1, -1, pct);
            for (int g = 0; g < $urandom_range(1, 3); g++)
                step(1'b0, 8'($urandom), ($urandom_range(0, 99) < pct));
        end
        for (int g = 0; g < 40; g++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
